// File: rtl/cam_sensor_emu.sv
// Camera sensor emulator: divides clk_i into cam_pclk and produces HREF-style
// luma frames (VSYNC, VBP, ACTIVE, VFP) with a selectable 8-bit test pattern.
module cam_sensor_emu #(
    parameter int unsigned PCLK_DIV  = 2,
    parameter int unsigned H_ACTIVE  = 160,
    parameter int unsigned H_BLANK   = 20,
    parameter int unsigned VS_LINES  = 1,
    parameter int unsigned VBP_LINES = 2,
    parameter int unsigned V_ACTIVE  = 120,
    parameter int unsigned VFP_LINES = 1
) (
    input  logic       clk_i,
    input  logic       reset_n,
    input  logic       cam_rst,
    input  logic       cam_enb,
    input  logic [1:0] pattern,
    output logic [7:0] cam_y,
    output logic       cam_pclk,
    output logic       cam_hsync,
    output logic       cam_vsync,
    output logic       frame_done,
    output logic [7:0] frame_cnt
);

    localparam int unsigned LINE = H_ACTIVE + H_BLANK;
    localparam int unsigned DW   = (PCLK_DIV > 1) ? $clog2(PCLK_DIV) : 1;
    localparam int unsigned XW   = (LINE > 1) ? $clog2(LINE) : 1;
    localparam int unsigned LW   = 16;

    localparam logic [DW-1:0] DIV_LAST = DW'(PCLK_DIV - 1);
    localparam logic [XW-1:0] X_LAST   = XW'(LINE - 1);
    localparam logic [XW-1:0] X_ACT    = XW'(H_ACTIVE);
    localparam logic [LW-1:0] VS_LAST  = LW'(VS_LINES - 1);
    localparam logic [LW-1:0] VBP_LAST = LW'(VBP_LINES - 1);
    localparam logic [LW-1:0] VA_LAST  = LW'(V_ACTIVE - 1);
    localparam logic [LW-1:0] VFP_LAST = LW'(VFP_LINES - 1);

    typedef enum logic [2:0] {IDLE, VSYNC, VBP, ACTIVE, VFP} state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic          pclk_q, pclk_d;
    logic [XW-1:0] x_q, x_d;
    logic [LW-1:0] lc_q, lc_d;
    logic [7:0]    cam_y_q, cam_y_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          frame_done_q, frame_done_d;
    logic [7:0]    frame_cnt_q, frame_cnt_d;

    logic          tick;
    logic          line_end;
    logic          frame_end;
    logic [7:0]    pix;

    always_comb begin
        state_d      = state_q;
        div_cnt_d    = div_cnt_q;
        pclk_d       = pclk_q;
        x_d          = x_q;
        lc_d         = lc_q;
        cam_y_d      = cam_y_q;
        hsync_d      = hsync_q;
        vsync_d      = vsync_q;
        frame_done_d = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        tick         = 1'b0;
        line_end     = 1'b0;
        frame_end    = 1'b0;
        pix          = '0;

        if (cam_rst) begin
            state_d     = IDLE;
            div_cnt_d   = '0;
            pclk_d      = 1'b0;
            x_d         = '0;
            lc_d        = '0;
            cam_y_d     = '0;
            hsync_d     = 1'b0;
            vsync_d     = 1'b0;
            frame_cnt_d = '0;
        end else begin
            if (div_cnt_q == DIV_LAST) begin
                div_cnt_d = '0;
                pclk_d    = ~pclk_q;
            end else begin
                div_cnt_d = div_cnt_q + DW'(1);
            end
            tick = (div_cnt_q == DIV_LAST) && pclk_q;

            if (tick) begin
                line_end = (x_q == X_LAST);
                x_d      = line_end ? '0 : x_q + XW'(1);
                if (state_q == IDLE) begin
                    x_d  = '0;
                    lc_d = '0;
                    if (cam_enb) state_d = VSYNC;
                end else if (line_end) begin
                    lc_d = lc_q + LW'(1);
                    unique case (state_q)
                        VSYNC: if (lc_q == VS_LAST) begin
                            lc_d    = '0;
                            state_d = (VBP_LINES != 0) ? VBP : ACTIVE;
                        end
                        VBP: if (lc_q == VBP_LAST) begin
                            lc_d    = '0;
                            state_d = ACTIVE;
                        end
                        ACTIVE: if (lc_q == VA_LAST) begin
                            lc_d = '0;
                            if (VFP_LINES != 0) state_d = VFP;
                            else                frame_end = 1'b1;
                        end
                        VFP: if (lc_q == VFP_LAST) begin
                            lc_d      = '0;
                            frame_end = 1'b1;
                        end
                        default: ;
                    endcase
                    if (frame_end) begin
                        state_d      = cam_enb ? VSYNC : IDLE;
                        frame_done_d = 1'b1;
                        frame_cnt_d  = frame_cnt_q + 8'd1;
                    end
                end

                // Outputs describe the pixel at the position just entered on this tick.
                unique case (pattern)
                    2'd0:    pix = 8'(x_d);
                    2'd1:    pix = 8'(lc_d);
                    2'd2:    pix = 8'(x_d) + 8'(lc_d) + frame_cnt_q;
                    default: pix = 8'hA5;
                endcase
                vsync_d = (state_d == VSYNC);
                hsync_d = (state_d == ACTIVE) && (x_d < X_ACT);
                cam_y_d = hsync_d ? pix : '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            div_cnt_q    <= '0;
            pclk_q       <= 1'b0;
            x_q          <= '0;
            lc_q         <= '0;
            cam_y_q      <= '0;
            hsync_q      <= 1'b0;
            vsync_q      <= 1'b0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            div_cnt_q    <= div_cnt_d;
            pclk_q       <= pclk_d;
            x_q          <= x_d;
            lc_q         <= lc_d;
            cam_y_q      <= cam_y_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign cam_y      = cam_y_q;
    assign cam_pclk   = pclk_q;
    assign cam_hsync  = hsync_q;
    assign cam_vsync  = vsync_q;
    assign frame_done = frame_done_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_cam_sensor_emu.sv
// Directed bench for cam_sensor_emu using per-tick expected vectors for whole
// frames plus hand sequences for reset, cam_rst and frame counter wrap.
module tb_cam_sensor_emu;

    logic       clk_i = 1'b0;
    logic       reset_n;
    logic       cam_rst;
    logic       cam_enb;
    logic [1:0] pattern;
    logic [7:0] cam_y;
    logic       cam_pclk;
    logic       cam_hsync;
    logic       cam_vsync;
    logic       frame_done;
    logic [7:0] frame_cnt;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    typedef struct {
        logic       enb;
        logic [1:0] pat;
        logic [7:0] y;
        logic       hs;
        logic       vs;
        logic       fd;
        logic [7:0] fc;
    } vec_t;

    vec_t vq[$];

    cam_sensor_emu #(
        .PCLK_DIV (1),
        .H_ACTIVE (4),
        .H_BLANK  (2),
        .VS_LINES (1),
        .VBP_LINES(1),
        .V_ACTIVE (3),
        .VFP_LINES(1)
    ) dut (
        .clk_i     (clk_i),
        .reset_n   (reset_n),
        .cam_rst   (cam_rst),
        .cam_enb   (cam_enb),
        .pattern   (pattern),
        .cam_y     (cam_y),
        .cam_pclk  (cam_pclk),
        .cam_hsync (cam_hsync),
        .cam_vsync (cam_vsync),
        .frame_done(frame_done),
        .frame_cnt (frame_cnt)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Frame of 6 lines x 6 pixels: line 0 vsync, line 1 back porch,
    // lines 2..4 active (4 pixels each), line 5 front porch.
    function automatic void add_frame(input logic [1:0] pat, input int alt_line,
                                      input logic [1:0] alt_pat, input logic [7:0] fc,
                                      input logic fd0, input int drop_line);
        vec_t v;
        logic [7:0] row, xx;
        for (int l = 0; l < 6; l++) begin
            for (int x = 0; x < 6; x++) begin
                v.enb = (l < drop_line);
                v.pat = (l == alt_line) ? alt_pat : pat;
                v.vs  = (l == 0);
                v.hs  = (l >= 2) && (l <= 4) && (x < 4);
                row   = 8'(l - 2);
                xx    = 8'(x);
                if (!v.hs)            v.y = 8'h00;
                else if (v.pat == 2'd0) v.y = xx;
                else if (v.pat == 2'd1) v.y = row;
                else if (v.pat == 2'd2) v.y = xx + row + fc;
                else                  v.y = 8'hA5;
                v.fd = fd0 && (l == 0) && (x == 0);
                v.fc = fc;
                vq.push_back(v);
            end
        end
    endfunction

    task automatic wait_tick(output bit ok);
        logic prev;
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            prev = cam_pclk;
            @(posedge clk_i);
            #1;
            if (prev && !cam_pclk) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_vecs(input int unsigned start);
        bit ok;
        logic [18:0] act, exp;
        for (int unsigned i = start; i < vq.size(); i++) begin
            cam_enb = vq[i].enb;
            pattern = vq[i].pat;
            wait_tick(ok);
            act = {cam_y, cam_hsync, cam_vsync, frame_done, frame_cnt};
            exp = {vq[i].y, vq[i].hs, vq[i].vs, vq[i].fd, vq[i].fc};
            n_checks++;
            if (!ok || act !== exp) begin
                n_fail++;
                $display("FAIL vec[%0d] tick=%0b got y=%h hs=%b vs=%b fd=%b fc=%0d expected y=%h hs=%b vs=%b fd=%b fc=%0d",
                         i, ok, act[18:11], act[10], act[9], act[8], act[7:0],
                         exp[18:11], exp[10], exp[9], exp[8], exp[7:0]);
            end
            if (vq[i].fd) begin
                @(posedge clk_i);
                #1;
                check($sformatf("frame_done_width[%0d]", i), 32'(frame_done), 32'd0);
            end
        end
    endtask

    task automatic skip_ticks(input int n);
        bit ok;
        for (int i = 0; i < n; i++) begin
            wait_tick(ok);
            if (!ok) check("tick_timeout", 32'd0, 32'd1);
        end
    endtask

    initial begin
        bit ok;
        int unsigned frames;
        reset_n = 1'b0;
        cam_rst = 1'b0;
        cam_enb = 1'b0;
        pattern = 2'd0;

        // Power-on reset and free-running pclk while disabled.
        #22;
        check("reset_outputs", {cam_y, cam_pclk, cam_hsync, cam_vsync, frame_done, frame_cnt}, '0);
        @(negedge clk_i);
        reset_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk_i);
            #1;
            check($sformatf("idle_pclk[%0d]", k), 32'(cam_pclk), (k % 2 == 0) ? 32'd1 : 32'd0);
            check($sformatf("idle_sync[%0d]", k), {30'd0, cam_hsync, cam_vsync}, 32'd0);
        end

        // Frame 1 pattern 0, frame 2 pattern 2, frame 3 pattern 1 with A5 on
        // active line 2 and cam_enb dropped at active line 1, then idle.
        add_frame(2'd0, 99, 2'd0, 8'd0, 1'b0, 99);
        add_frame(2'd2, 99, 2'd0, 8'd1, 1'b1, 99);
        add_frame(2'd1, 4,  2'd3, 8'd2, 1'b1, 3);
        vq.push_back('{1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b1, 8'd3});
        for (int k = 0; k < 4; k++) vq.push_back('{1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd3});
        run_vecs(0);

        // cam_rst pulse during ACTIVE.
        cam_enb = 1'b1;
        pattern = 2'd3;
        skip_ticks(13);
        check("pre_rst_active", {cam_y, cam_hsync, frame_cnt}, {8'hA5, 1'b1, 8'd3});
        cam_rst = 1'b1;
        @(posedge clk_i);
        #1;
        cam_rst = 1'b0;
        check("cam_rst_outputs", {cam_y, cam_pclk, cam_hsync, cam_vsync, frame_done, frame_cnt}, '0);
        wait_tick(ok);
        check("rst_first_tick_vsync", {ok, cam_vsync, cam_hsync, frame_cnt}, {1'b1, 1'b1, 1'b0, 8'd0});

        // Run up to frame_cnt=255, then across the wrap with pattern 2.
        pattern = 2'd2;
        frames  = 0;
        for (int c = 0; c < 20000 && frames < 255; c++) begin
            @(posedge clk_i);
            #1;
            if (frame_done) frames++;
        end
        check("wrap_frames_seen", frames, 32'd255);
        check("frame_cnt_255", 32'(frame_cnt), 32'd255);
        vq.delete();
        add_frame(2'd2, 99, 2'd0, 8'd255, 1'b1, 99);
        add_frame(2'd2, 99, 2'd0, 8'd0,   1'b1, 99);
        run_vecs(1);

        // Async reset asserted mid-line.
        pattern = 2'd3;
        skip_ticks(13);
        check("pre_async_active", {cam_y, cam_hsync, frame_cnt}, {8'hA5, 1'b1, 8'd1});
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_outputs", {cam_y, cam_pclk, cam_hsync, cam_vsync, frame_done, frame_cnt}, '0);
        cam_enb = 1'b0;
        @(negedge clk_i);
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk_i);
            #1;
            check($sformatf("post_reset_pclk[%0d]", k), {cam_pclk, cam_hsync, cam_vsync},
                  (k % 2 == 0) ? 32'd4 : 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
